// File: rtl/fpu_pkg.sv
// Shared FPU constants and the normaliser FSM state encoding.
package fpu_pkg;
  localparam int MANT_W     = 28;
  localparam int EXP_W      = 8;
  localparam int HIDDEN_BIT = 26;
  localparam int GRS_W      = 3;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } norm_state_e;
endpackage

// File: rtl/mant_addsub.sv
// Combinational mantissa add/subtract with zero detect, shared by FPU stages.
module mant_addsub #(
  parameter int W = 28
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         zero_o
);
  assign sum_o  = sub_i ? (a_i - b_i) : (a_i + b_i);
  assign zero_o = (sum_o == '0);
endmodule

// File: rtl/fpu_addsub_mant_norm.sv
// FPU add/sub mantissa stage: add or subtract, then normalise one bit per cycle.
// state | meaning: IDLE accept operands; ADD sum + carry fix-up; NORM left-shift to hidden bit; DONE hold result
module fpu_addsub_mant_norm
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              S_O,
  input  logic              AS,
  input  logic [MANT_W-1:0] MA_IN,
  input  logic [MANT_W-1:0] MB_IN,
  input  logic [EXP_W-1:0]  EXP_IN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_ovf
);
  localparam logic [EXP_W-1:0] EXP_ONE = 8'd1;

  norm_state_e       state_q, state_d;
  logic              sign_q, sign_d;
  logic              as_q, as_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic [MANT_W-1:0] ma_q, ma_d;
  logic [MANT_W-1:0] mb_q, mb_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;

  logic [MANT_W-1:0] sum;
  logic              sum_zero;
  logic [EXP_W-1:0]  exp_inc;

  mant_addsub #(.W(MANT_W)) u_addsub (
    .a_i    (ma_q),
    .b_i    (mb_q),
    .sub_i  (as_q),
    .sum_o  (sum),
    .zero_o (sum_zero)
  );

  assign exp_inc = exp_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      as_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      as_q    <= as_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    as_d    = as_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = S_O;
          as_d    = AS;
          ma_d    = MA_IN;
          mb_d    = MB_IN;
          exp_d   = EXP_IN;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          mant_d  = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        state_d = ST_NORM;
        if (sum_zero) begin
          // Round-to-nearest yields +0 for an exact cancellation.
          zero_d = 1'b1;
          sign_d = 1'b0;
          exp_d  = '0;
          mant_d = '0;
        end else if (sum[MANT_W-1]) begin
          exp_d = exp_inc;
          if (exp_inc == EXP_MAX) begin
            ovf_d  = 1'b1;
            mant_d = '0;
          end else begin
            mant_d = {1'b0, sum[MANT_W-1:2], sum[1] | sum[0]};
          end
        end else begin
          mant_d = sum;
        end
      end
      ST_NORM: begin
        if (zero_q || ovf_q || mant_q[HIDDEN_BIT]) begin
          state_d = ST_DONE;
        end else if (exp_q == EXP_ONE) begin
          exp_d   = '0;
          state_d = ST_DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_mant  = mant_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
endmodule
